// File: rtl/nes_bus_pkg.sv
// Shared types and address map for the NES CPU-side bus controller.
package nes_bus_pkg;

  typedef enum logic [2:0] {
    RGN_RAM,
    RGN_PPU,
    RGN_DMA,
    RGN_CTRL,
    RGN_PRG,
    RGN_NONE
  } region_e;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_ALIGN,
    DMA_RD,
    DMA_WR
  } dma_state_e;

  localparam logic [15:0] RAM_END   = 16'h1FFF;
  localparam logic [15:0] PPU_END   = 16'h3FFF;
  localparam logic [15:0] DMA_REG   = 16'h4014;
  localparam logic [15:0] CTRL_BASE = 16'h4016;
  localparam logic [15:0] PRG_BASE  = 16'h8000;

  // Map a 16-bit CPU address onto the region that answers it.
  function automatic region_e decode_region(input logic [15:0] addr, input int num_ctrl);
    region_e rgn;
    int      ctrl_off;
    ctrl_off = int'(addr) - int'(CTRL_BASE);
    if (addr <= RAM_END)                          rgn = RGN_RAM;
    else if (addr <= PPU_END)                     rgn = RGN_PPU;
    else if (addr == DMA_REG)                     rgn = RGN_DMA;
    else if (ctrl_off >= 0 && ctrl_off < num_ctrl) rgn = RGN_CTRL;
    else if (addr >= PRG_BASE)                    rgn = RGN_PRG;
    else                                          rgn = RGN_NONE;
    return rgn;
  endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// $4014 OAM DMA engine: one alignment cycle, then 256 read/write pairs
// copying page P into OAM while the CPU is held off the bus.
module oam_dma_engine
  import nes_bus_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DMA_LEN = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [7:0]        page_i,
  input  logic [DATA_W-1:0] src_q_i,
  output logic              rdy_o,
  output logic              rd_o,
  output logic [15:0]       addr_o,
  output logic              oam_we_o,
  output logic [7:0]        oam_addr_o,
  output logic [DATA_W-1:0] oam_d_o
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dma_state_e state_q, state_d;
  logic [7:0] idx_q;
  logic [7:0] page_q;

  // State register; reset aborts any transfer in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= DMA_IDLE;
    else       state_q <= state_d;
  end

  // Byte index and source page; idx advances after each OAM write and wraps at 256.
  always_ff @(posedge clk_i) begin
    if (rst_i)                    idx_q <= '0;
    else if (start_i)             idx_q <= '0;
    else if (state_q == DMA_WR)   idx_q <= idx_q + 8'd1;
    if (start_i) page_q <= page_i;
  end

  // Next-state: ALIGN burns one cycle, then alternate RD/WR until the last byte.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DMA_IDLE:  if (start_i) state_d = DMA_ALIGN;
      DMA_ALIGN: state_d = DMA_RD;
      DMA_RD:    state_d = DMA_WR;
      DMA_WR:    state_d = (idx_q == LAST_IDX) ? DMA_IDLE : DMA_RD;
      default:   state_d = DMA_IDLE;
    endcase
  end

  // Outputs: CPU stalled whenever busy; OAM written with the byte fetched in RD.
  always_comb begin
    rdy_o      = (state_q == DMA_IDLE);
    rd_o       = (state_q == DMA_RD);
    oam_we_o   = (state_q == DMA_WR);
    addr_o     = {page_q, idx_q};
    oam_addr_o = idx_q;
    oam_d_o    = src_q_i;
  end

endmodule

// File: rtl/cpu_bus_ctrl.sv
// CPU-side bus controller: address decode, registered read mux with
// open-bus emulation, controller port strobes and OAM DMA arbitration.
module cpu_bus_ctrl
  import nes_bus_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int RAM_AW   = 11,
  parameter int PPU_RW   = 3,
  parameter int NUM_CTRL = 2,
  parameter int DMA_LEN  = 256
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [15:0]         CPU_ADDR,
  input  logic                CPU_RW,
  input  logic [DATA_W-1:0]   CPU_DO,
  output logic [DATA_W-1:0]   CPU_DI,
  output logic                CPU_RDY,
  output logic [15:0]         MEM_ADDR,
  input  logic [DATA_W-1:0]   SYSRAM_Q,
  output logic                SYSRAM_WE,
  output logic [DATA_W-1:0]   SYSRAM_D,
  input  logic [DATA_W-1:0]   PRGROM_Q,
  output logic                PPU_CS,
  output logic [PPU_RW-1:0]   PPU_REG,
  input  logic [DATA_W-1:0]   PPU_Q,
  output logic                OAM_WE,
  output logic [7:0]          OAM_ADDR,
  output logic [DATA_W-1:0]   OAM_D,
  input  logic [NUM_CTRL-1:0] CTRL_BIT,
  output logic [NUM_CTRL-1:0] CTRL_RD,
  output logic                CTRL_STROBE
);

  logic              dma_rd;
  logic [15:0]       dma_addr;
  logic [15:0]       bus_addr;
  region_e           rgn;
  logic              cpu_wr, cpu_rd, rd_launch, dma_start, ctrl_sel;
  logic [DATA_W-1:0] rd_data;

  logic                rd_vld_q, rd_vld_d;
  region_e             rd_sel_q, rd_sel_d;
  logic                ctrl_sel_q, ctrl_sel_d;
  logic [NUM_CTRL-1:0] ctrl_rd_q, ctrl_rd_d;
  logic                strobe_q, strobe_d;
  logic [DATA_W-1:0]   ob_q, ob_d;
  logic [DATA_W-1:0]   cpu_di_q, cpu_di_d;

  // The CPU owns the bus only while the DMA engine is idle.
  assign bus_addr  = CPU_RDY ? CPU_ADDR : dma_addr;
  assign rgn       = decode_region(bus_addr, NUM_CTRL);
  assign cpu_wr    = CPU_RDY & ~CPU_RW;
  assign cpu_rd    = CPU_RDY & CPU_RW;
  assign rd_launch = cpu_rd | dma_rd;
  assign dma_start = cpu_wr & (rgn == RGN_DMA);
  // CTRL_BASE is even, so the port index is the address LSB.
  assign ctrl_sel  = bus_addr[0];

  assign MEM_ADDR    = bus_addr;
  assign SYSRAM_WE   = cpu_wr & (rgn == RGN_RAM);
  assign SYSRAM_D    = CPU_DO;
  assign PPU_CS      = (CPU_RDY | dma_rd) & (rgn == RGN_PPU);
  assign PPU_REG     = bus_addr[PPU_RW-1:0];
  assign CTRL_RD     = ctrl_rd_q;
  assign CTRL_STROBE = strobe_q;
  assign CPU_DI      = rd_vld_q ? rd_data : cpu_di_q;

  // Read mux for the access launched last cycle; unmapped sources float to open bus.
  always_comb begin
    rd_data = ob_q;
    case (rd_sel_q)
      RGN_RAM:  rd_data = SYSRAM_Q;
      RGN_PPU:  rd_data = PPU_Q;
      RGN_PRG:  rd_data = PRGROM_Q;
      RGN_CTRL: rd_data = {ob_q[DATA_W-1:1], CTRL_BIT[ctrl_sel_q]};
      default:  rd_data = ob_q;
    endcase
  end

  // Next-state for the read pipeline, controller strobes and open-bus latch.
  always_comb begin
    rd_vld_d   = rd_launch;
    rd_sel_d   = rgn;
    // DMA fetches see only RAM/PPU/PRG; anything else reads open bus.
    if (dma_rd && (rgn == RGN_CTRL || rgn == RGN_DMA)) rd_sel_d = RGN_NONE;
    ctrl_sel_d = ctrl_sel;
    ctrl_rd_d  = '0;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (cpu_rd && rgn == RGN_CTRL && ctrl_sel == 1'(i)) ctrl_rd_d[i] = 1'b1;
    end
    strobe_d = strobe_q;
    if (cpu_wr && rgn == RGN_CTRL && !ctrl_sel) strobe_d = CPU_DO[0];
    ob_d = ob_q;
    if (rd_vld_q) ob_d = rd_data;
    if (cpu_wr)   ob_d = CPU_DO;
    cpu_di_d = rd_vld_q ? rd_data : cpu_di_q;
  end

  // Register read pipeline and bus-visible state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_vld_q   <= 1'b0;
      rd_sel_q   <= RGN_NONE;
      ctrl_sel_q <= 1'b0;
      ctrl_rd_q  <= '0;
      strobe_q   <= 1'b0;
      ob_q       <= '0;
      cpu_di_q   <= '0;
    end else begin
      rd_vld_q   <= rd_vld_d;
      rd_sel_q   <= rd_sel_d;
      ctrl_sel_q <= ctrl_sel_d;
      ctrl_rd_q  <= ctrl_rd_d;
      strobe_q   <= strobe_d;
      ob_q       <= ob_d;
      cpu_di_q   <= cpu_di_d;
    end
  end

  oam_dma_engine #(
    .DATA_W  (DATA_W),
    .DMA_LEN (DMA_LEN)
  ) u_dma (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .start_i    (dma_start),
    .page_i     (CPU_DO[7:0]),
    .src_q_i    (rd_data),
    .rdy_o      (CPU_RDY),
    .rd_o       (dma_rd),
    .addr_o     (dma_addr),
    .oam_we_o   (OAM_WE),
    .oam_addr_o (OAM_ADDR),
    .oam_d_o    (OAM_D)
  );

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Directed bench for cpu_bus_ctrl with simple 1-cycle-latency memory models.
module tb_cpu_bus_ctrl;

  logic        Clk, Reset;
  logic [15:0] CPU_ADDR;
  logic        CPU_RW;
  logic [7:0]  CPU_DO, CPU_DI;
  logic        CPU_RDY;
  logic [15:0] MEM_ADDR;
  logic [7:0]  SYSRAM_Q, SYSRAM_D, PRGROM_Q, PPU_Q, OAM_D;
  logic        SYSRAM_WE, PPU_CS, OAM_WE, CTRL_STROBE;
  logic [2:0]  PPU_REG;
  logic [7:0]  OAM_ADDR;
  logic [1:0]  CTRL_BIT, CTRL_RD;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] ram [0:2047];

  cpu_bus_ctrl dut (
    .Clk(Clk), .Reset(Reset), .CPU_ADDR(CPU_ADDR), .CPU_RW(CPU_RW), .CPU_DO(CPU_DO),
    .CPU_DI(CPU_DI), .CPU_RDY(CPU_RDY), .MEM_ADDR(MEM_ADDR), .SYSRAM_Q(SYSRAM_Q),
    .SYSRAM_WE(SYSRAM_WE), .SYSRAM_D(SYSRAM_D), .PRGROM_Q(PRGROM_Q), .PPU_CS(PPU_CS),
    .PPU_REG(PPU_REG), .PPU_Q(PPU_Q), .OAM_WE(OAM_WE), .OAM_ADDR(OAM_ADDR), .OAM_D(OAM_D),
    .CTRL_BIT(CTRL_BIT), .CTRL_RD(CTRL_RD), .CTRL_STROBE(CTRL_STROBE)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory models: RAM holds low address byte (except $0001), PRG returns ~addr, PPU returns C0|reg.
  always @(posedge Clk) begin
    SYSRAM_Q <= ram[MEM_ADDR[10:0]];
    PRGROM_Q <= ~MEM_ADDR[7:0];
    PPU_Q    <= {5'b11000, MEM_ADDR[2:0]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic bus(input logic rw, input logic [15:0] addr, input logic [7:0] dout);
    CPU_RW   = rw;
    CPU_ADDR = addr;
    CPU_DO   = dout;
    #1;
  endtask

  int          low, pulses, bad, found;
  logic [15:0] prev_mem;

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 8'(i);
    ram[1] = 8'h5A;
    Reset = 1'b1; CPU_ADDR = 16'h5000; CPU_RW = 1'b1; CPU_DO = 8'h00; CTRL_BIT = 2'b00;
    repeat (2) @(posedge Clk);
    #2;
    chk("rst_cpu_di",  32'(CPU_DI), 32'h00);
    chk("rst_rdy",     32'(CPU_RDY), 32'd1);
    chk("rst_oam_we",  32'(OAM_WE), 32'd0);
    chk("rst_oam_adr", 32'(OAM_ADDR), 32'd0);
    chk("rst_strobe",  32'(CTRL_STROBE), 32'd0);
    chk("rst_ctrl_rd", 32'(CTRL_RD), 32'd0);
    chk("rst_ram_we",  32'(SYSRAM_WE), 32'd0);
    tick();
    Reset = 1'b0;

    // SYSRAM mirror read, then PRG read, then unmapped
    bus(1'b1, 16'h0801, 8'h00); chk("ram_mem_addr", 32'(MEM_ADDR), 32'h0801); tick();
    bus(1'b1, 16'h8058, 8'h00); chk("ram_rd_data", 32'(CPU_DI), 32'h5A); tick();
    bus(1'b1, 16'h5000, 8'h00);
    chk("prg_rd_data", 32'(CPU_DI), 32'hA7);
    chk("unm_ram_we", 32'(SYSRAM_WE), 32'd0);
    chk("unm_ppu_cs", 32'(PPU_CS), 32'd0);
    chk("unm_ctrl_rd", 32'(CTRL_RD), 32'd0);
    chk("unm_oam_we", 32'(OAM_WE), 32'd0);
    tick();
    bus(1'b1, 16'h5000, 8'h00); chk("unm_open_bus", 32'(CPU_DI), 32'hA7); tick();

    // Controller strobe and port read
    bus(1'b0, 16'h4016, 8'h01); chk("ctrl_wr_ram_we", 32'(SYSRAM_WE), 32'd0); tick();
    bus(1'b0, 16'h4016, 8'h00); chk("strobe_hi", 32'(CTRL_STROBE), 32'd1); tick();
    bus(1'b0, 16'h5000, 8'h40); chk("strobe_lo", 32'(CTRL_STROBE), 32'd0); tick();
    CTRL_BIT = 2'b10;
    bus(1'b1, 16'h4017, 8'h00); chk("ctrl_rd_early", 32'(CTRL_RD), 32'd0); tick();
    bus(1'b1, 16'h5000, 8'h00);
    chk("ctrl_rd_pulse", 32'(CTRL_RD), 32'b10);
    chk("ctrl_rd_data", 32'(CPU_DI), 32'h41);
    tick();
    bus(1'b1, 16'h5000, 8'h00);
    chk("ctrl_rd_end", 32'(CTRL_RD), 32'd0);
    chk("ctrl_ob_hold", 32'(CPU_DI), 32'h41);
    tick();

    // PPU register mirrors and dropped PRG write
    bus(1'b0, 16'h2009, 8'h33);
    chk("ppu_wr_cs", 32'(PPU_CS), 32'd1);
    chk("ppu_wr_reg", 32'(PPU_REG), 32'd1);
    chk("ppu_wr_ram_we", 32'(SYSRAM_WE), 32'd0);
    tick();
    bus(1'b1, 16'h3FFE, 8'h00);
    chk("ppu_rd_cs", 32'(PPU_CS), 32'd1);
    chk("ppu_rd_reg", 32'(PPU_REG), 32'd6);
    tick();
    bus(1'b0, 16'h8000, 8'h55);
    chk("ppu_rd_data", 32'(CPU_DI), 32'hC6);
    chk("prg_wr_ram_we", 32'(SYSRAM_WE), 32'd0);
    chk("prg_wr_ppu_cs", 32'(PPU_CS), 32'd0);
    tick();
    bus(1'b0, 16'h0005, 8'h77);
    chk("ram_wr_we", 32'(SYSRAM_WE), 32'd1);
    chk("ram_wr_d", 32'(SYSRAM_D), 32'h77);
    tick();

    // Full OAM DMA from page $02; CPU drives a write that must be ignored
    bus(1'b0, 16'h4014, 8'h02); chk("dma_rdy_pre", 32'(CPU_RDY), 32'd1); tick();
    CPU_RW = 1'b0; CPU_ADDR = 16'h0000; CPU_DO = 8'hFF;
    low = 0; pulses = 0; bad = 0; prev_mem = 16'h0000;
    for (int i = 0; i < 600; i++) begin
      #1;
      if (CPU_RDY) break;
      low++;
      if (SYSRAM_WE || PPU_CS) bad++;
      if (OAM_WE) begin
        if (OAM_ADDR !== pulses[7:0] || OAM_D !== pulses[7:0] ||
            prev_mem !== 16'h0200 + pulses[15:0]) bad++;
        pulses++;
      end
      prev_mem = MEM_ADDR;
      @(posedge Clk); #1;
    end
    CPU_RW = 1'b1; CPU_ADDR = 16'h5000;
    #1;
    chk("dma_low_cycles", 32'(low), 32'd513);
    chk("dma_pulses", 32'(pulses), 32'd256);
    chk("dma_bad_beats", 32'(bad), 32'd0);
    chk("dma_done_we", 32'(OAM_WE), 32'd0);
    chk("dma_done_addr", 32'(OAM_ADDR), 32'd0);
    tick();

    // Reset in the middle of a DMA, then restart
    bus(1'b0, 16'h4014, 8'h02); tick();
    CPU_RW = 1'b1; CPU_ADDR = 16'h5000;
    found = 0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (OAM_WE && OAM_ADDR == 8'd100) begin found = 1; break; end
      @(posedge Clk); #1;
    end
    chk("abort_found", 32'(found), 32'd1);
    Reset = 1'b1; tick(); Reset = 1'b0; #1;
    chk("abort_rdy", 32'(CPU_RDY), 32'd1);
    chk("abort_we", 32'(OAM_WE), 32'd0);
    chk("abort_addr", 32'(OAM_ADDR), 32'd0);
    chk("abort_cpu_di", 32'(CPU_DI), 32'd0);
    bad = 0;
    repeat (5) begin
      tick(); #1;
      if (OAM_WE || !CPU_RDY) bad++;
    end
    chk("abort_quiet", 32'(bad), 32'd0);
    tick();
    bus(1'b0, 16'h4014, 8'h03); tick();
    CPU_RW = 1'b1; CPU_ADDR = 16'h5000;
    found = 0; prev_mem = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (OAM_WE) begin found = 1; break; end
      prev_mem = MEM_ADDR;
      @(posedge Clk); #1;
    end
    chk("restart_found", 32'(found), 32'd1);
    chk("restart_idx", 32'(OAM_ADDR), 32'd0);
    chk("restart_data", 32'(OAM_D), 32'd0);
    chk("restart_mem", 32'(prev_mem), 32'h0300);
    for (int i = 0; i < 600; i++) begin
      if (CPU_RDY) break;
      tick(); #1;
    end
    chk("restart_done", 32'(CPU_RDY), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_bus_ctrl.md
Name: cpu_bus_ctrl

Overview:
- Second-generation CPU-side bus controller for the NES core: address decode, sync-memory read muxing, open-bus emulation, controller port strobes and the $4014 OAM DMA engine.
- Sits between the 6502 core and SYSRAM, PRGROM, the PPU register file and the controller shift registers.
- Unlike the first-generation combinational decoder:
  - read data is registered, matching the 1-cycle on-chip RAM/ROM latency;
  - unmapped reads return the last bus value;
  - DMA stalls the CPU and masters the bus.

Parameters:
- DATA_W, 8, data bus width.
- RAM_AW, 11, SYSRAM address width; $0000-$1FFF mirrors modulo 2^RAM_AW.
- PPU_RW, 3, PPU register index width; $2000-$3FFF mirrors modulo 2^PPU_RW.
- NUM_CTRL, 2, controller ports mapped at $4016 upward (max 2).
- DMA_LEN, 256, bytes per OAM DMA.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- CPU_ADDR  in  16  CPU address.
- CPU_RW  in  1  1=read, 0=write.
- CPU_DO  in  DATA_W  CPU write data.
- CPU_DI  out  DATA_W  read data to CPU; valid the cycle after the address.
- CPU_RDY  out  1  0 stalls the CPU (DMA active).
- MEM_ADDR  out  16  address to SYSRAM/PRGROM; CPU_ADDR or the DMA address.
- SYSRAM_Q  in  DATA_W  SYSRAM read data (1-cycle latency).
- SYSRAM_WE  out  1  SYSRAM write enable.
- SYSRAM_D  out  DATA_W  SYSRAM write data.
- PRGROM_Q  in  DATA_W  PRG ROM read data (1-cycle latency).
- PPU_CS  out  1  PPU register access this cycle.
- PPU_REG  out  PPU_RW  PPU register index.
- PPU_Q  in  DATA_W  PPU register read data (1-cycle latency).
- OAM_WE  out  1  OAM write strobe.
- OAM_ADDR  out  8  OAM byte index.
- OAM_D  out  DATA_W  OAM write data.
- CTRL_BIT  in  NUM_CTRL  serial bit from each controller.
- CTRL_RD  out  NUM_CTRL  1-cycle shift pulse per controller read.
- CTRL_STROBE  out  1  latched bit 0 of the last $4016 write.

Behaviour:
- Reset values:
  - CPU_DI=0, CPU_RDY=1, all enables and strobes 0, OAM_ADDR=0, CTRL_STROBE=0;
  - open-bus latch=0, DMA FSM in IDLE.
  - Reset mid-DMA aborts immediately; no further OAM_WE pulses are produced.
- Decode is combinational on CPU_ADDR in IDLE only:
  - $0000-$1FFF -> SYSRAM;
  - $2000-$3FFF -> PPU (PPU_REG = ADDR[PPU_RW-1:0]);
  - $4014 -> DMA trigger;
  - $4016+i (i<NUM_CTRL) -> controller i;
  - $8000-$FFFF -> PRG;
  - everything else unmapped.
- Writes (CPU_RW=0):
  - SYSRAM_WE=1, SYSRAM_D=CPU_DO;
  - PPU_CS=1;
  - $4016 sets CTRL_STROBE<=CPU_DO[0] on the next edge;
  - writes to PRG or unmapped addresses are dropped.
- Reads:
  - The source select is registered at edge n; CPU_DI is muxed from the selected Q during cycle n+1, and that value is also registered into CPU_DI and the open-bus latch.
  - Controller read returns {open_bus[DATA_W-1:1], CTRL_BIT[i]} and pulses CTRL_RD[i] for exactly one cycle.
  - Unmapped read returns open_bus unchanged.
- Open-bus latch updates on every completed read and every CPU write (with CPU_DO).
- DMA FSM: IDLE -> ALIGN -> RD -> WR -> RD ... -> IDLE.
  - A write to $4014 with page P: next cycle CPU_RDY=0 and the FSM enters ALIGN (1 dummy cycle).
  - RD: MEM_ADDR = {P, idx}.
  - WR: OAM_WE=1, OAM_D = source Q, OAM_ADDR=idx; then idx++.
  - After idx = DMA_LEN-1 the WR state returns to IDLE and CPU_RDY=1 on the following cycle.
  - CPU_RDY is low for exactly 1+2*DMA_LEN cycles.
  - DMA reads use the same SYSRAM/PRG/unmapped decode as the CPU; a source page in $2000-$3FFF reads PPU_Q.
  - DMA never writes SYSRAM.
  - CPU_ADDR/CPU_RW are ignored while CPU_RDY=0.
- OAM_ADDR wraps modulo 256; idx is an 8-bit counter.

Decomposition:
- Package nes_bus_pkg:
  - region enum {RGN_RAM, RGN_PPU, RGN_DMA, RGN_CTRL, RGN_PRG, RGN_NONE};
  - DMA state enum;
  - address constants: RAM_END=16'h1FFF, PPU_END=16'h3FFF, DMA_REG=16'h4014, CTRL_BASE=16'h4016, PRG_BASE=16'h8000.
- One sub-module, oam_dma_engine, containing the FSM, idx counter and OAM outputs.
- Decode and read mux remain in the top level.

Test Plan:
- Read $0801 with SYSRAM_Q=8'h5A returned on the next cycle -> MEM_ADDR=$0801, CPU_DI=8'h5A one cycle later (mirror of $0001).
- Write 8'h01 then 8'h00 to $4016, then read $4017 with CTRL_BIT=2'b10 and open_bus=8'h40 -> CTRL_STROBE 1 then 0; CTRL_RD=2'b10 for 1 cycle; CPU_DI=8'h41.
- Read $5000 immediately after a read returning 8'hA7 -> CPU_DI=8'hA7; no enables asserted.
- Write 8'h02 to $4014 with SYSRAM_Q=low byte of the address -> CPU_RDY low for 513 cycles; 256 OAM_WE pulses with OAM_ADDR=k, OAM_D=k, MEM_ADDR $0200-$02FF.
- Assert Reset at DMA idx=100 -> next cycle CPU_RDY=1, OAM_WE=0, FSM in IDLE; a new $4014 write restarts at idx 0.
- Write to $2009 and read $3FFE -> PPU_CS=1 with PPU_REG=1 and 6 respectively; write to $8000 -> no write enable asserted.
